// File: rtl/uart_tx_frame.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, one stop bit. One clk cycle is one bit period.
//
// Ports:
//   clk        TX bit clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   p_data     parallel byte to send
//   data_valid send request, sampled only while busy=0
//   par_en     1 = append a parity bit after the data bits
//   par_type   EVEN(0) / ODD(1) parity sense
//   tx_out     registered serial line, idle high
//   busy       registered, high from start bit through stop bit
module uart_tx_frame #(
    parameter int   DATA_WIDTH = 8,
    parameter logic EVEN       = 1'b0,
    parameter logic ODD        = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_type,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // State names the bit currently on the line.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_out_q, tx_out_d;
    logic                  busy_q, busy_d;
    logic                  par_calc;

    always_comb begin
        par_calc = ^p_data;
        case (par_type)
            EVEN:    par_calc = ^p_data;
            ODD:     par_calc = ~^p_data;
            default: par_calc = ^p_data;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_out_d  = 1'b1;
        busy_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (data_valid) begin
                    shift_d   = p_data;
                    par_en_d  = par_en;
                    par_bit_d = par_calc;
                    tx_out_d  = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                tx_out_d = shift_q[0];
                shift_d  = shift_q >> 1;
                cnt_d    = '0;
                state_d  = S_DATA;
            end
            S_DATA: begin
                if (cnt_q == LAST_BIT) begin
                    if (par_en_q) begin
                        tx_out_d = par_bit_q;
                        state_d  = S_PARITY;
                    end else begin
                        state_d  = S_STOP;
                    end
                end else begin
                    tx_out_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_out = tx_out_q;
    assign busy   = busy_q;

endmodule
